// File: rtl/clint_tmr_if.sv
// Simple peripheral bus between the core and the CLINT timer block.
// Valid/ready request channel plus valid/ready response channel.
// The master drives requests and response-ready; the slave answers.
interface clint_tmr_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdat;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdat;
    logic        rsp_err;

    modport master (
        output req_vld, req_wen, req_addr, req_wdat, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdat, rsp_err
    );

    modport slave (
        input  req_vld, req_wen, req_addr, req_wdat, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdat, rsp_err
    );
endinterface

// File: rtl/clint_tmr.sv
// Core-local interruptor: mtime/mtimecmp machine timer plus msip software interrupt.
// Latency: response one cycle after request accept; tmr_ip registered from next-state values.
// Backpressure: single outstanding response, req_rdy = !rsp_vld | rsp_rdy; response held until consumed.
module clint_tmr #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic       clk,
    input  logic       rst,
    clint_tmr_if.slave bus,
    output logic       tmr_ip,
    output logic       sft_ip
);
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        rsp_vld_q, rsp_err_q;
    logic [31:0] rsp_rdat_q;

    logic        acc, wr, in_win, hit, tick;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_tm_lo, sel_tm_hi;
    logic [31:0] rd_dat;

    assign bus.req_rdy  = !rsp_vld_q || bus.rsp_rdy;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_rdat = rsp_rdat_q;
    assign bus.rsp_err  = rsp_err_q;
    assign sft_ip       = msip_q;

    assign acc    = bus.req_vld && bus.req_rdy;
    assign wr     = acc && bus.req_wen;
    assign in_win = (bus.req_addr[31:16] == BASE_ADDR[31:16]);

    assign sel_msip   = in_win && (bus.req_addr[15:0] == 16'h0000);
    assign sel_cmp_lo = in_win && (bus.req_addr[15:0] == 16'h4000);
    assign sel_cmp_hi = in_win && (bus.req_addr[15:0] == 16'h4004);
    assign sel_tm_lo  = in_win && (bus.req_addr[15:0] == 16'hBFF8);
    assign sel_tm_hi  = in_win && (bus.req_addr[15:0] == 16'hBFFC);
    assign hit        = sel_msip || sel_cmp_lo || sel_cmp_hi || sel_tm_lo || sel_tm_hi;

    assign tick = (pcnt_q == DIV_LAST);

    // Read data always reflects the register contents before this edge's update.
    always_comb begin
        rd_dat = '0;
        if (sel_msip)   rd_dat = {31'd0, msip_q};
        if (sel_cmp_lo) rd_dat = mtimecmp_q[31:0];
        if (sel_cmp_hi) rd_dat = mtimecmp_q[63:32];
        if (sel_tm_lo)  rd_dat = mtime_q[31:0];
        if (sel_tm_hi)  rd_dat = mtime_q[63:32];
    end

    always_comb begin
        mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
        pcnt_d     = tick ? 16'd0 : (pcnt_q + 16'd1);
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // A write to either mtime half overrides the tick: other half keeps its old value.
        if (wr && sel_tm_lo) begin
            mtime_d = {mtime_q[63:32], bus.req_wdat};
            pcnt_d  = 16'd0;
        end
        if (wr && sel_tm_hi) begin
            mtime_d = {bus.req_wdat, mtime_q[31:0]};
            pcnt_d  = 16'd0;
        end
        if (wr && sel_cmp_lo) mtimecmp_d = {mtimecmp_q[63:32], bus.req_wdat};
        if (wr && sel_cmp_hi) mtimecmp_d = {bus.req_wdat, mtimecmp_q[31:0]};
        if (wr && sel_msip)   msip_d     = bus.req_wdat[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q     <= 1'b0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            pcnt_q     <= 16'd0;
            tmr_ip     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rdat_q <= 32'd0;
        end else begin
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pcnt_q     <= pcnt_d;
            tmr_ip     <= (mtime_d >= mtimecmp_d);
            if (acc) begin
                rsp_vld_q  <= 1'b1;
                rsp_err_q  <= !hit;
                rsp_rdat_q <= bus.req_wen ? 32'd0 : rd_dat;
            end else if (bus.rsp_rdy) begin
                rsp_vld_q  <= 1'b0;
                rsp_err_q  <= 1'b0;
                rsp_rdat_q <= 32'd0;
            end
        end
    end
endmodule
